// File: rtl/commit_trace_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : commit_trace_buf_pkg                                          |
// | Purpose  : Shared state encoding and entry-width helper for the commit   |
// |            trace buffer.                                                 |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package commit_trace_buf_pkg;

  // Encodings are visible on the state output, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_POST   = 2'b10,
    ST_FROZEN = 2'b11
  } trace_state_e;

  // One trace record is {pc, dest, value}.
  function automatic int entry_width(input int pc_w, input int dest_w, input int val_w);
    return pc_w + dest_w + val_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_buf_trace_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : trace_ram                                                     |
// | Purpose  : Simple dual-port DEPTH x WIDTH storage, one write port and    |
// |            one registered read port. Array contents are not reset; only  |
// |            the read register is.                                         |
// | Ports    : clk, rst           clock, async active-high reset             |
// |            we, waddr, wdata   write port                                 |
// |            re, raddr          read enable / address                      |
// |            rdata              registered read data                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is read-before-write when addresses collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_trace_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : commit_trace_buf                                              |
// | Purpose  : On-chip ROB commit trace. Records every commit into a         |
// |            circular buffer, stops POST_TRIG commits after a PC-match,    |
// |            external or watchdog trigger, then holds the window for       |
// |            readout. Observation only; never back-pressures the CPU.      |
// | Ports    : clk_in, rst_in     clock, async active-high reset             |
// |            rdy_in             global ready, low freezes all state        |
// |            commit_*           ROB commit port (valid, pc, dest, value)   |
// |            arm, ext_trig      capture control pulses                     |
// |            trig_pc_en/trig_pc PC-match trigger                           |
// |            rd_addr/rd_data    oldest-relative readout, 1-cycle latency   |
// |            state, count       capture state and valid entry count        |
// |            trig_index         trigger record position (valid in FROZEN)  |
// |            wd_fired           sticky watchdog-trigger flag               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module commit_trace_buf
  import commit_trace_buf_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int VAL_W     = 32,
  parameter int DEST_W    = 5,
  parameter int POST_TRIG = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            commit_valid,
  input  logic [PC_W-1:0]                 commit_pc,
  input  logic [DEST_W-1:0]               commit_dest,
  input  logic [VAL_W-1:0]                commit_value,
  input  logic                            arm,
  input  logic                            ext_trig,
  input  logic                            trig_pc_en,
  input  logic [PC_W-1:0]                 trig_pc,
  input  logic [$clog2(DEPTH)-1:0]        rd_addr,
  output logic [PC_W+DEST_W+VAL_W-1:0]    rd_data,
  output logic [1:0]                      state,
  output logic [$clog2(DEPTH):0]          count,
  output logic [$clog2(DEPTH)-1:0]        trig_index,
  output logic                            wd_fired
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_width(PC_W, DEST_W, VAL_W);
  localparam int WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int PCNT_W  = (POST_TRIG < 2) ? 1 : $clog2(POST_TRIG + 1);

  localparam logic [AW:0]       FULL      = (AW+1)'(DEPTH);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [PCNT_W-1:0] POST_LAST = PCNT_W'(POST_TRIG - 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
      $error("commit_trace_buf: DEPTH must be a power of 2 and >= 2");
    end
    if (POST_TRIG >= DEPTH) begin : g_chk_post
      $error("commit_trace_buf: POST_TRIG must be < DEPTH");
    end
  endgenerate

  trace_state_e        st;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       trig_ptr;
  logic [PCNT_W-1:0]   post_cnt;
  logic [WD_W-1:0]     wd_cnt;

  logic                capturing;
  logic                do_write;
  logic                wd_hit;
  logic                pc_hit;
  logic                trig_armed;
  logic [AW:0]         count_inc;
  logic [AW-1:0]       wr_ptr_inc;
  logic [AW-1:0]       cur_trig_ptr;
  logic [AW-1:0]       oldest;
  logic [AW-1:0]       oldest_after;
  logic [AW-1:0]       frz_oldest;
  logic [AW-1:0]       rd_phys;

  assign state = st;

  always_comb begin
    capturing  = (st == ST_ARMED) || (st == ST_POST);
    // arm clears the buffer, so a commit coinciding with it is not kept.
    do_write   = rdy_in && capturing && commit_valid && !arm;
    wd_hit     = (TIMEOUT != 0) && capturing && !commit_valid && (wd_cnt == WD_LAST);
    pc_hit     = trig_pc_en && commit_valid && (commit_pc == trig_pc);
    trig_armed = (st == ST_ARMED) && (ext_trig || pc_hit || wd_hit);

    count_inc  = (count == FULL) ? count : count + (AW+1)'(1);
    wr_ptr_inc = wr_ptr + AW'(1);

    // Trigger record: the commit in flight, else the last one recorded.
    // With an empty buffer there is no record; pin it to slot 0.
    if (commit_valid) begin
      cur_trig_ptr = wr_ptr;
    end else if (count == '0) begin
      cur_trig_ptr = '0;
    end else begin
      cur_trig_ptr = wr_ptr - AW'(1);
    end

    oldest       = (count == FULL) ? wr_ptr : '0;
    // Window origin as it will be after this cycle's write, used when the
    // freeze coincides with a write.
    oldest_after = (count_inc == FULL) ? wr_ptr_inc : '0;
    frz_oldest   = do_write ? oldest_after : oldest;

    rd_phys      = oldest + rd_addr;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st         <= ST_IDLE;
      wr_ptr     <= '0;
      trig_ptr   <= '0;
      post_cnt   <= '0;
      wd_cnt     <= '0;
      count      <= '0;
      trig_index <= '0;
      wd_fired   <= 1'b0;
    end else if (rdy_in) begin
      if (do_write) begin
        wr_ptr <= wr_ptr_inc;
        count  <= count_inc;
      end
      if (capturing) begin
        wd_cnt <= commit_valid ? '0 : wd_cnt + WD_W'(1);
      end

      case (st)
        ST_ARMED: begin
          if (arm) begin
            st       <= ST_ARMED;
            count    <= '0;
            wr_ptr   <= '0;
            wd_cnt   <= '0;
            wd_fired <= 1'b0;
            post_cnt <= '0;
          end else if (trig_armed) begin
            trig_ptr <= cur_trig_ptr;
            post_cnt <= '0;
            wd_cnt   <= '0;
            if (wd_hit) begin
              wd_fired <= 1'b1;
            end
            if (POST_TRIG == 0) begin
              st         <= ST_FROZEN;
              trig_index <= cur_trig_ptr - frz_oldest;
            end else begin
              st <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (arm) begin
            st       <= ST_ARMED;
            count    <= '0;
            wr_ptr   <= '0;
            wd_cnt   <= '0;
            wd_fired <= 1'b0;
            post_cnt <= '0;
          end else if (wd_hit) begin
            // CPU stopped committing mid-window: freeze what we have.
            st         <= ST_FROZEN;
            wd_fired   <= 1'b1;
            wd_cnt     <= '0;
            trig_index <= trig_ptr - oldest;
          end else if (do_write) begin
            post_cnt <= post_cnt + PCNT_W'(1);
            if (post_cnt == POST_LAST) begin
              st         <= ST_FROZEN;
              trig_index <= trig_ptr - frz_oldest;
            end
          end
        end

        default: begin
          // IDLE and FROZEN: only arm has an effect.
          if (arm) begin
            st       <= ST_ARMED;
            count    <= '0;
            wr_ptr   <= '0;
            wd_cnt   <= '0;
            wd_fired <= 1'b0;
            post_cnt <= '0;
          end
        end
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk_in),
    .rst   (rst_in),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata ({commit_pc, commit_dest, commit_value}),
    .re    (rdy_in),
    .raddr (rd_phys),
    .rdata (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_commit_trace_buf                                           |
// | Purpose  : Directed self-checking bench for commit_trace_buf with a      |
// |            readout scoreboard (expected entries queued at rd_addr drive, |
// |            popped when rd_data is valid).                                |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_commit_trace_buf;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int ENTRY_W = 69;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               rdy_in;
  logic               commit_valid;
  logic [31:0]        commit_pc;
  logic [4:0]         commit_dest;
  logic [31:0]        commit_value;
  logic               arm;
  logic               ext_trig;
  logic               trig_pc_en;
  logic [31:0]        trig_pc;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic [1:0]         state;
  logic [AW:0]        count;
  logic [AW-1:0]      trig_index;
  logic               wd_fired;

  int tests = 0;
  int fails = 0;
  logic [ENTRY_W-1:0] exp_q [$];

  commit_trace_buf #(
    .DEPTH(16), .PC_W(32), .VAL_W(32), .DEST_W(5), .POST_TRIG(8), .TIMEOUT(1024)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .arm          (arm),
    .ext_trig     (ext_trig),
    .trig_pc_en   (trig_pc_en),
    .trig_pc      (trig_pc),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .state        (state),
    .count        (count),
    .trig_index   (trig_index),
    .wd_fired     (wd_fired)
  );

  always #5 clk_in = ~clk_in;

  // Commit k of a sequence: pc = base+4k, dest = k, value = A5000000+k.
  function automatic logic [ENTRY_W-1:0] ent(input logic [31:0] base, input int k);
    return {base + 32'(4 * k), 5'(k), 32'hA500_0000 + 32'(k)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic commit_k(input logic [31:0] base, input int k);
    commit_valid = 1'b1;
    {commit_pc, commit_dest, commit_value} = ent(base, k);
    step(1);
    commit_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [ENTRY_W-1:0] exp);
    logic [ENTRY_W-1:0] e;
    rd_addr = AW'(addr);
    exp_q.push_back(exp);
    step(1);
    e = exp_q.pop_front();
    chk(tag, rd_data, e);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; commit_valid = 1'b0; commit_pc = '0;
    commit_dest = '0; commit_value = '0; arm = 1'b0; ext_trig = 1'b0;
    trig_pc_en = 1'b0; trig_pc = '0; rd_addr = '0;
    step(2);
    chk("rst_state", state, 2'b00);
    chk("rst_count", count, 0);
    chk("rst_trig_index", trig_index, 0);
    chk("rst_wd_fired", wd_fired, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_in = 1'b0;

    // Commits in IDLE are ignored.
    for (int k = 0; k < 3; k++) commit_k(32'h0900, k);
    chk("idle_count", count, 0);
    chk("idle_state", state, 2'b00);

    // PC-match trigger on third commit, freeze after 8 further commits.
    trig_pc_en = 1'b1; trig_pc = 32'h1008;
    pulse_arm();
    chk("arm_state", state, 2'b01);
    chk("arm_count", count, 0);
    for (int k = 0; k < 3; k++) commit_k(32'h1000, k);
    chk("pcm_state_post", state, 2'b10);
    chk("pcm_count3", count, 3);
    for (int k = 3; k < 10; k++) commit_k(32'h1000, k);
    chk("pcm_still_post", state, 2'b10);
    commit_k(32'h1000, 10);
    chk("pcm_frozen", state, 2'b11);
    chk("pcm_count11", count, 11);
    chk("pcm_trig_index", trig_index, 2);
    rd_chk("pcm_rd0", 0, ent(32'h1000, 0));
    rd_chk("pcm_rd2", 2, ent(32'h1000, 2));
    rd_chk("pcm_rd10", 10, ent(32'h1000, 10));
    commit_k(32'h1000, 11);
    chk("frozen_no_write", count, 11);

    // Wrap: ext trigger on commit 30; PC match and ext_trig in POST ignored.
    trig_pc = 32'h2000 + 32'(4 * 33);
    pulse_arm();
    for (int k = 0; k < 30; k++) commit_k(32'h2000, k);
    chk("wrap_armed", state, 2'b01);
    chk("wrap_count_sat", count, 16);
    ext_trig = 1'b1;
    commit_k(32'h2000, 30);
    ext_trig = 1'b0;
    chk("wrap_post", state, 2'b10);
    for (int k = 31; k < 38; k++) begin
      ext_trig = (k == 35);
      commit_k(32'h2000, k);
      ext_trig = 1'b0;
    end
    chk("wrap_post_after_retrig", state, 2'b10);
    commit_k(32'h2000, 38);
    chk("wrap_frozen", state, 2'b11);
    chk("wrap_count", count, 16);
    chk("wrap_trig_index", trig_index, 7);
    rd_chk("wrap_rd0", 0, ent(32'h2000, 23));
    rd_chk("wrap_rd7", 7, ent(32'h2000, 30));
    rd_chk("wrap_rd15", 15, ent(32'h2000, 38));
    trig_pc_en = 1'b0;

    // Watchdog with 3 recorded commits.
    pulse_arm();
    for (int k = 0; k < 3; k++) commit_k(32'h3000, k);
    step(1023);
    chk("wd_not_yet", state, 2'b01);
    step(1);
    chk("wd_post", state, 2'b10);
    chk("wd_fired_set", wd_fired, 1);
    step(1023);
    chk("wd_post_hold", state, 2'b10);
    step(1);
    chk("wd_frozen", state, 2'b11);
    chk("wd_count", count, 3);
    chk("wd_trig_index", trig_index, 2);

    // Watchdog with empty buffer.
    pulse_arm();
    chk("wd_arm_clears", wd_fired, 0);
    step(1024);
    chk("wd0_post", state, 2'b10);
    chk("wd0_count", count, 0);
    step(1024);
    chk("wd0_frozen", state, 2'b11);
    chk("wd0_trig_index", trig_index, 0);
    chk("wd0_fired", wd_fired, 1);

    // arm and ext_trig together in ARMED: arm wins.
    pulse_arm();
    commit_k(32'h4000, 0);
    commit_k(32'h4000, 1);
    arm = 1'b1; ext_trig = 1'b1;
    step(1);
    arm = 1'b0; ext_trig = 1'b0;
    chk("armtrig_state", state, 2'b01);
    chk("armtrig_count", count, 0);
    commit_k(32'h4000, 0);
    chk("armtrig_count1", count, 1);
    rd_chk("armtrig_rd0", 0, ent(32'h4000, 0));

    // rdy_in low: commits, triggers and readout all held.
    rdy_in = 1'b0;
    commit_valid = 1'b1;
    {commit_pc, commit_dest, commit_value} = ent(32'h5000, 9);
    ext_trig = 1'b1;
    rd_addr = AW'(5);
    step(50);
    commit_valid = 1'b0; ext_trig = 1'b0;
    chk("rdy_count", count, 1);
    chk("rdy_state", state, 2'b01);
    chk("rdy_rd_hold", rd_data, ent(32'h4000, 0));
    step(1100);
    chk("rdy_wd_held", state, 2'b01);
    rdy_in = 1'b1;
    step(1);
    chk("rdy_resume_state", state, 2'b01);
    rd_chk("rdy_mem_untouched", 1, ent(32'h4000, 1));

    // Asynchronous reset in POST.
    ext_trig = 1'b1;
    step(1);
    ext_trig = 1'b0;
    commit_k(32'h6000, 0);
    commit_k(32'h6000, 1);
    chk("midpost_state", state, 2'b10);
    rst_in = 1'b1;
    #2;
    chk("async_rst_state", state, 2'b00);
    chk("async_rst_count", count, 0);
    chk("async_rst_wd", wd_fired, 0);
    step(1);
    rst_in = 1'b0;
    for (int k = 0; k < 3; k++) commit_k(32'h7000, k);
    chk("post_rst_count", count, 0);
    chk("post_rst_state", state, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
